// File: rtl/cpu_pkg.sv
// Shared rename/ROB types and sizing.
// Imported by the rename stage and its free list.
package cpu_pkg;
  localparam int ARCH_REGS = 32;
  localparam int PHYS_REGS = 64;
  localparam int ROB_DEPTH = 32;

  typedef logic [5:0] preg_t;
  typedef logic [4:0] areg_t;
  typedef logic [4:0] rob_idx_t;

  typedef struct packed {
    logic     vld;
    preg_t    psrc_a;
    preg_t    psrc_b;
    preg_t    curr;
    preg_t    old;
    rob_idx_t rob_idx;
  } rename_out_t;
endpackage

// File: rtl/free_list_alloc.sv
// Physical register free list: bitmap, two lowest-free picks,
// a running free count and two release ports.
import cpu_pkg::*;

module free_list_alloc (
  input  logic       clk,
  input  logic       reset,
  input  logic       take_1,
  input  logic       take_2,
  input  logic       free_vld_1,
  input  logic [5:0] free_reg_1,
  input  logic       free_vld_2,
  input  logic [5:0] free_reg_2,
  output logic [5:0] pick_1,
  output logic [5:0] pick_2,
  output logic [6:0] free_count
);
  logic [PHYS_REGS-1:0] bitmap;
  logic [PHYS_REGS-1:0] bitmap_nxt;
  logic                 found_1;
  logic                 found_2;
  logic                 set_1;
  logic                 set_2;
  logic [6:0]           n_take;
  logic [6:0]           n_set;

  always_comb begin
    pick_1  = '0;
    pick_2  = '0;
    found_1 = 1'b0;
    found_2 = 1'b0;
    for (int i = 0; i < PHYS_REGS; i++) begin
      if (bitmap[i]) begin
        if (!found_1) begin
          pick_1  = preg_t'(i);
          found_1 = 1'b1;
        end else if (!found_2) begin
          pick_2  = preg_t'(i);
          found_2 = 1'b1;
        end
      end
    end
  end

  // only bits that actually flip 0->1 count toward the free total
  assign set_1 = free_vld_1 && (free_reg_1 != '0)
              && !bitmap[free_reg_1];
  assign set_2 = free_vld_2 && (free_reg_2 != '0)
              && !bitmap[free_reg_2]
              && !(set_1 && free_reg_2 == free_reg_1);

  assign n_take = 7'(take_1) + 7'(take_2);
  assign n_set  = 7'(set_1) + 7'(set_2);

  always_comb begin
    bitmap_nxt = bitmap;
    if (take_1) bitmap_nxt[pick_1] = 1'b0;
    if (take_2) bitmap_nxt[pick_2] = 1'b0;
    if (free_vld_1 && free_reg_1 != '0)
      bitmap_nxt[free_reg_1] = 1'b1;
    if (free_vld_2 && free_reg_2 != '0)
      bitmap_nxt[free_reg_2] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bitmap     <= {{32{1'b1}}, {32{1'b0}}};
      free_count <= 7'd32;
    end else begin
      bitmap     <= bitmap_nxt;
      free_count <= free_count - n_take + n_set;
    end
  end

  always @(posedge clk) begin
    if (!reset && free_vld_1 && free_reg_1 != '0)
      assert (!bitmap[free_reg_1]);
    if (!reset && free_vld_2 && free_reg_2 != '0)
      assert (!bitmap[free_reg_2]);
  end
endmodule

// File: rtl/rename_stage.sv
// 2-wide rename: RAT lookup, dest allocation, ROB index
// assignment and retire-side register reclaim.
import cpu_pkg::*;

module rename_stage (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       inst_vld_1,
  input  logic       inst_vld_2,
  input  logic [4:0] src_a_1,
  input  logic [4:0] src_a_2,
  input  logic [4:0] src_b_1,
  input  logic [4:0] src_b_2,
  input  logic [4:0] dst_1,
  input  logic [4:0] dst_2,
  output logic       out_valid,
  output logic       out_vld_1,
  output logic       out_vld_2,
  output logic [5:0] psrc_a_1,
  output logic [5:0] psrc_a_2,
  output logic [5:0] psrc_b_1,
  output logic [5:0] psrc_b_2,
  output logic [5:0] curr_dest_reg_1,
  output logic [5:0] curr_dest_reg_2,
  output logic [5:0] old_dest_reg_1,
  output logic [5:0] old_dest_reg_2,
  output logic [4:0] rob_index_1,
  output logic [4:0] rob_index_2,
  input  logic       free_vld_1,
  input  logic       free_vld_2,
  input  logic [5:0] free_reg_1,
  input  logic [5:0] free_reg_2,
  input  logic [1:0] commit_cnt
);
  preg_t       rat [ARCH_REGS];
  rob_idx_t    rob_tail;
  logic [5:0]  rob_count;
  logic [6:0]  free_count;
  logic [6:0]  rob_space;
  preg_t       pick_1;
  preg_t       pick_2;
  preg_t       curr_1;
  preg_t       curr_2;
  logic        need_1;
  logic        need_2;
  logic [1:0]  regs_needed;
  logic [1:0]  rob_needed;
  logic [1:0]  rob_used;
  logic        accept;
  logic        take_1;
  logic        take_2;
  rename_out_t s1_d;
  rename_out_t s2_d;
  rename_out_t s1_q;
  rename_out_t s2_q;
  logic        out_valid_q;

  assign need_1 = inst_vld_1 && (dst_1 != '0);
  assign need_2 = inst_vld_2 && (dst_2 != '0);

  assign regs_needed = 2'(need_1) + 2'(need_2);
  assign rob_needed  = 2'(inst_vld_1) + 2'(inst_vld_2);
  assign rob_space   = 7'(ROB_DEPTH) - {1'b0, rob_count};

  assign in_ready = !reset
                 && (free_count >= 7'(regs_needed))
                 && (rob_space >= 7'(rob_needed));
  assign accept   = in_valid && in_ready;
  assign rob_used = accept ? rob_needed : 2'd0;

  // second dest takes pick_1 when slot 1 allocates nothing
  assign take_1 = accept && (need_1 || need_2);
  assign take_2 = accept && need_1 && need_2;
  assign curr_1 = need_1 ? pick_1 : '0;
  assign curr_2 = !need_2 ? '0 : (need_1 ? pick_2 : pick_1);

  free_list_alloc u_free (
    .clk        (clk),
    .reset      (reset),
    .take_1     (take_1),
    .take_2     (take_2),
    .free_vld_1 (free_vld_1),
    .free_reg_1 (free_reg_1),
    .free_vld_2 (free_vld_2),
    .free_reg_2 (free_reg_2),
    .pick_1     (pick_1),
    .pick_2     (pick_2),
    .free_count (free_count)
  );

  always_comb begin
    s1_d = '0;
    if (inst_vld_1) begin
      s1_d.vld     = 1'b1;
      s1_d.psrc_a  = (src_a_1 == '0) ? '0 : rat[src_a_1];
      s1_d.psrc_b  = (src_b_1 == '0) ? '0 : rat[src_b_1];
      s1_d.curr    = curr_1;
      s1_d.old     = need_1 ? rat[dst_1] : '0;
      s1_d.rob_idx = rob_tail;
    end
  end

  // slot 2 sees slot 1's fresh mapping of a shared register
  always_comb begin
    s2_d = '0;
    if (inst_vld_2) begin
      s2_d.vld = 1'b1;
      unique case (1'b1)
        src_a_2 == '0:
          s2_d.psrc_a = '0;
        need_1 && src_a_2 == dst_1:
          s2_d.psrc_a = curr_1;
        default:
          s2_d.psrc_a = rat[src_a_2];
      endcase
      unique case (1'b1)
        src_b_2 == '0:
          s2_d.psrc_b = '0;
        need_1 && src_b_2 == dst_1:
          s2_d.psrc_b = curr_1;
        default:
          s2_d.psrc_b = rat[src_b_2];
      endcase
      unique case (1'b1)
        !need_2:
          s2_d.old = '0;
        need_1 && dst_2 == dst_1:
          s2_d.old = curr_1;
        default:
          s2_d.old = rat[dst_2];
      endcase
      s2_d.curr    = curr_2;
      s2_d.rob_idx = rob_tail + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++)
        rat[i] <= preg_t'(i);
      rob_tail    <= '0;
      rob_count   <= '0;
      out_valid_q <= 1'b0;
      s1_q        <= '0;
      s2_q        <= '0;
    end else begin
      if (accept && need_1) rat[dst_1] <= curr_1;
      if (accept && need_2) rat[dst_2] <= curr_2;
      rob_tail    <= rob_tail + rob_idx_t'(rob_used);
      rob_count   <= rob_count + 6'(rob_used)
                   - 6'(commit_cnt);
      out_valid_q <= accept;
      s1_q        <= accept ? s1_d : '0;
      s2_q        <= accept ? s2_d : '0;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_vld_1       = s1_q.vld;
  assign out_vld_2       = s2_q.vld;
  assign psrc_a_1        = s1_q.psrc_a;
  assign psrc_a_2        = s2_q.psrc_a;
  assign psrc_b_1        = s1_q.psrc_b;
  assign psrc_b_2        = s2_q.psrc_b;
  assign curr_dest_reg_1 = s1_q.curr;
  assign curr_dest_reg_2 = s2_q.curr;
  assign old_dest_reg_1  = s1_q.old;
  assign old_dest_reg_2  = s2_q.old;
  assign rob_index_1     = s1_q.rob_idx;
  assign rob_index_2     = s2_q.rob_idx;
endmodule

// File: tb/tb_rename_stage.sv
// Scoreboard bench for rename_stage: directed scenarios plus
// random traffic against a sequential rename model.
import cpu_pkg::*;

module tb_rename_stage;
  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic       inst_vld_1, inst_vld_2;
  logic [4:0] src_a_1, src_a_2, src_b_1, src_b_2;
  logic [4:0] dst_1, dst_2;
  logic       out_valid, out_vld_1, out_vld_2;
  logic [5:0] psrc_a_1, psrc_a_2, psrc_b_1, psrc_b_2;
  logic [5:0] curr_dest_reg_1, curr_dest_reg_2;
  logic [5:0] old_dest_reg_1, old_dest_reg_2;
  logic [4:0] rob_index_1, rob_index_2;
  logic       free_vld_1, free_vld_2;
  logic [5:0] free_reg_1, free_reg_2;
  logic [1:0] commit_cnt;

  rename_stage dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .inst_vld_1      (inst_vld_1),
    .inst_vld_2      (inst_vld_2),
    .src_a_1         (src_a_1),
    .src_a_2         (src_a_2),
    .src_b_1         (src_b_1),
    .src_b_2         (src_b_2),
    .dst_1           (dst_1),
    .dst_2           (dst_2),
    .out_valid       (out_valid),
    .out_vld_1       (out_vld_1),
    .out_vld_2       (out_vld_2),
    .psrc_a_1        (psrc_a_1),
    .psrc_a_2        (psrc_a_2),
    .psrc_b_1        (psrc_b_1),
    .psrc_b_2        (psrc_b_2),
    .curr_dest_reg_1 (curr_dest_reg_1),
    .curr_dest_reg_2 (curr_dest_reg_2),
    .old_dest_reg_1  (old_dest_reg_1),
    .old_dest_reg_2  (old_dest_reg_2),
    .rob_index_1     (rob_index_1),
    .rob_index_2     (rob_index_2),
    .free_vld_1      (free_vld_1),
    .free_vld_2      (free_vld_2),
    .free_reg_1      (free_reg_1),
    .free_reg_2      (free_reg_2),
    .commit_cnt      (commit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    rename_out_t s1;
    rename_out_t s2;
  } exp_t;

  exp_t sb[$];
  int   retire_q[$];
  int   m_rat [32];
  bit   m_free [64];
  int   m_tail;
  int   m_cnt;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rat[i] = i;
    for (int i = 0; i < 64; i++) m_free[i] = (i >= 32);
    m_tail = 0;
    m_cnt  = 0;
    retire_q.delete();
  endtask

  function automatic int free_total();
    int n = 0;
    for (int i = 0; i < 64; i++) n += int'(m_free[i]);
    return n;
  endfunction

  // renames one instruction against the model's current map,
  // so a second slot naturally sees the first slot's update
  task automatic rename_one(input int sa, input int sb_,
                            input int d, input int rob,
                            output rename_out_t o);
    int c;
    o = '0;
    o.vld = 1'b1;
    o.psrc_a = (sa == 0) ? 6'd0 : preg_t'(m_rat[sa]);
    o.psrc_b = (sb_ == 0) ? 6'd0 : preg_t'(m_rat[sb_]);
    o.rob_idx = rob_idx_t'(rob % 32);
    if (d != 0) begin
      c = -1;
      for (int i = 0; i < 64 && c < 0; i++)
        if (m_free[i]) c = i;
      m_free[c] = 1'b0;
      o.old  = preg_t'(m_rat[d]);
      o.curr = preg_t'(c);
      m_rat[d] = c;
      retire_q.push_back(int'(o.old));
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    reset      = 1'b0;
    in_valid   = 1'b0;
    inst_vld_1 = 1'b0;
    inst_vld_2 = 1'b0;
    src_a_1    = '0;
    src_a_2    = '0;
    src_b_1    = '0;
    src_b_2    = '0;
    dst_1      = '0;
    dst_2      = '0;
    free_vld_1 = 1'b0;
    free_vld_2 = 1'b0;
    free_reg_1 = '0;
    free_reg_2 = '0;
    commit_cnt = '0;
  endtask

  // model the coming clock edge from the inputs now driven
  task automatic step();
    int   rn, robn, rdy;
    exp_t e;
    #1;
    if (reset) begin
      chk("in_ready_in_reset", int'(in_ready), 0);
      model_reset();
      return;
    end
    rn   = int'(inst_vld_1 && dst_1 != 0)
         + int'(inst_vld_2 && dst_2 != 0);
    robn = int'(inst_vld_1) + int'(inst_vld_2);
    rdy  = int'(free_total() >= rn && 32 - m_cnt >= robn);
    chk("in_ready", int'(in_ready), rdy);
    if (in_valid && rdy != 0) begin
      e.s1 = '0;
      e.s2 = '0;
      if (inst_vld_1)
        rename_one(int'(src_a_1), int'(src_b_1),
                   int'(dst_1), m_tail, e.s1);
      if (inst_vld_2)
        rename_one(int'(src_a_2), int'(src_b_2),
                   int'(dst_2), m_tail + 1, e.s2);
      sb.push_back(e);
      m_tail = (m_tail + robn) % 32;
      m_cnt += robn;
    end
    m_cnt -= int'(commit_cnt);
    if (free_vld_1 && free_reg_1 != 0) m_free[free_reg_1] = 1'b1;
    if (free_vld_2 && free_reg_2 != 0) m_free[free_reg_2] = 1'b1;
  endtask

  task automatic do_reset();
    nxt();
    reset = 1'b1;
    step();
    nxt();
    reset = 1'b1;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_curr_1", int'(curr_dest_reg_1), 0);
    chk("reset_old_1", int'(old_dest_reg_1), 0);
    step();
  endtask

  task automatic group(input int v2, input int sa1,
                       input int d1, input int sa2,
                       input int d2);
    in_valid   = 1'b1;
    inst_vld_1 = 1'b1;
    inst_vld_2 = v2[0];
    src_a_1    = areg_t'(sa1);
    src_b_1    = areg_t'(sa1 + 1);
    dst_1      = areg_t'(d1);
    src_a_2    = areg_t'(sa2);
    src_b_2    = areg_t'(sa2 + 2);
    dst_2      = areg_t'(d2);
  endtask

  task automatic cmp_slot(string name, rename_out_t act,
                          rename_out_t exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got v%0d a%0d b%0d c%0d o%0d r%0d %s",
               name, act.vld, act.psrc_a, act.psrc_b,
               act.curr, act.old, act.rob_idx, "");
      $display("  %s expected v%0d a%0d b%0d c%0d o%0d r%0d",
               name, exp.vld, exp.psrc_a, exp.psrc_b,
               exp.curr, exp.old, exp.rob_idx);
    end
  endtask

  initial begin : monitor
    exp_t        e;
    rename_out_t a1, a2;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out_valid: got 1 expected 0");
        end else begin
          e  = sb.pop_front();
          a1 = {out_vld_1, psrc_a_1, psrc_b_1,
                curr_dest_reg_1, old_dest_reg_1, rob_index_1};
          a2 = {out_vld_2, psrc_a_2, psrc_b_2,
                curr_dest_reg_2, old_dest_reg_2, rob_index_2};
          cmp_slot("slot1", a1, e.s1);
          cmp_slot("slot2", a2, e.s2);
        end
      end
    end
  end

  initial begin : stim
    int fv, cc;
    model_reset();
    do_reset();

    // first group after reset
    nxt();
    group(1, 1, 3, 2, 4);
    step();
    nxt();
    chk("t1_out_valid", int'(out_valid), 1);
    chk("t1_curr_1", int'(curr_dest_reg_1), 32);
    chk("t1_curr_2", int'(curr_dest_reg_2), 33);
    chk("t1_old_1", int'(old_dest_reg_1), 3);
    chk("t1_old_2", int'(old_dest_reg_2), 4);
    chk("t1_rob_1", int'(rob_index_1), 0);
    chk("t1_rob_2", int'(rob_index_2), 1);

    // intra-group dependency on r5
    group(1, 6, 5, 5, 5);
    step();
    nxt();
    chk("t2_psrc_a_2", int'(psrc_a_2), 34);
    chk("t2_old_2", int'(old_dest_reg_2), 34);
    chk("t2_curr_2", int'(curr_dest_reg_2), 35);
    group(0, 5, 0, 0, 0);
    step();
    nxt();
    chk("t2_later_src", int'(psrc_a_1), 35);
    step();

    // exhaust the free list
    do_reset();
    for (int k = 0; k < 16; k++) begin
      nxt();
      group(1, 3, 1, 4, 2);
      commit_cnt = (k > 0) ? 2'd2 : 2'd0;
      step();
    end
    nxt();
    group(1, 3, 1, 4, 2);
    step();
    chk("t3_blocked", int'(in_ready), 0);
    nxt();
    free_vld_1 = 1'b1;
    free_reg_1 = 6'd7;
    step();
    nxt();
    group(0, 3, 9, 0, 0);
    step();
    chk("t3_ready", int'(in_ready), 1);
    nxt();
    chk("t3_gets_p7", int'(curr_dest_reg_1), 7);
    step();

    // fill the ROB, then drain two and wrap
    do_reset();
    for (int k = 0; k < 16; k++) begin
      nxt();
      group(1, 1, 0, 2, 0);
      step();
    end
    nxt();
    group(0, 1, 0, 0, 0);
    step();
    chk("t4_rob_full", int'(in_ready), 0);
    nxt();
    commit_cnt = 2'd2;
    step();
    nxt();
    group(1, 1, 3, 2, 4);
    step();
    nxt();
    chk("t4_rob_1", int'(rob_index_1), 0);
    chk("t4_rob_2", int'(rob_index_2), 1);
    commit_cnt = 2'd2;
    step();

    // accept, commit and free in one edge
    nxt();
    group(1, 1, 5, 2, 6);
    commit_cnt = 2'd2;
    free_vld_1 = 1'b1;
    free_reg_1 = 6'd3;
    free_vld_2 = 1'b1;
    free_reg_2 = 6'd4;
    step();
    nxt();
    group(1, 1, 7, 2, 8);
    step();
    nxt();
    chk("t5_curr_1", int'(curr_dest_reg_1), 3);
    chk("t5_curr_2", int'(curr_dest_reg_2), 4);
    group(0, 1, 0, 0, 0);
    step();
    chk("t5_rob_full", int'(in_ready), 0);

    // reset in the middle of a stream
    do_reset();
    for (int k = 0; k < 3; k++) begin
      nxt();
      group(1, k + 1, k + 10, k + 2, k + 11);
      step();
    end
    nxt();
    group(1, 1, 12, 2, 13);
    reset = 1'b1;
    step();
    nxt();
    chk("t6_out_valid", int'(out_valid), 0);
    chk("t6_curr_1", int'(curr_dest_reg_1), 0);
    chk("t6_psrc_a_1", int'(psrc_a_1), 0);
    group(0, 10, 1, 0, 0);
    step();
    nxt();
    chk("t6_first_alloc", int'(curr_dest_reg_1), 32);
    chk("t6_rat_identity", int'(psrc_a_1), 10);
    step();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      nxt();
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        step();
        continue;
      end
      in_valid   = ($urandom_range(0, 3) != 0);
      inst_vld_1 = 1'b1;
      inst_vld_2 = $urandom_range(0, 1) == 1;
      src_a_1    = areg_t'($urandom_range(0, 31));
      src_b_1    = areg_t'($urandom_range(0, 31));
      src_a_2    = areg_t'($urandom_range(0, 31));
      src_b_2    = areg_t'($urandom_range(0, 31));
      dst_1      = ($urandom_range(0, 3) == 0) ? 5'd0
                 : areg_t'($urandom_range(1, 31));
      dst_2      = ($urandom_range(0, 3) == 0) ? 5'd0
                 : areg_t'($urandom_range(1, 31));
      if ($urandom_range(0, 3) == 0) dst_2 = dst_1;
      if ($urandom_range(0, 3) == 0) src_a_2 = dst_1;
      cc = (m_cnt < 2) ? m_cnt : 2;
      commit_cnt = 2'($urandom_range(0, cc));
      fv = $urandom_range(0, 2);
      if (fv >= 1 && retire_q.size() > 0) begin
        free_vld_1 = 1'b1;
        free_reg_1 = preg_t'(retire_q.pop_front());
      end
      if (fv == 2 && retire_q.size() > 0) begin
        free_vld_2 = 1'b1;
        free_reg_2 = preg_t'(retire_q.pop_front());
      end
      step();
    end

    for (int k = 0; k < 3; k++) begin
      nxt();
      step();
    end
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
